pipe_hazard_ctrl: RTL and testbench

- Central hazard/pipeline controller.
- Generates the stall (hold) and flush (bubble) controls consumed by the PC, IF/ID, ID/EX and EX/LS pipeline registers.
- Detection sources:
  - load-use hazards: EX-stage load vs ID-stage source registers;
  - EX-stage redirects: taken branch or jump;
  - multi-cycle MDU operations;
  - LSU memory handshake waits;
  - trap/commit flushes.
- Sits beside the decode stage and drives every inter-stage register.

---
 rtl/pipe_hazard_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline hazard controller: stall/flush generation for PC, IF/ID, ID/EX and EX/LS.
// Define PIPE_CTRL_PERF_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl #(
   parameter int unsigned REDIRECT_BUBBLES = 1,
   parameter int unsigned MDU_MAX_CYCLES   = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  id_rs1_addr,
   input  logic [4:0]  id_rs2_addr,
   input  logic        id_rs1_use,
   input  logic        id_rs2_use,
   input  logic [4:0]  ex_rd_addr,
   input  logic        ex_rd_ena,
   input  logic        ex_load_flag,
   input  logic        ex_redirect,
   input  logic        ex_mdu_start,
   input  logic        mdu_done,
   input  logic        ls_req,
   input  logic        ls_ack,
   input  logic        trap_flush,
   output logic        pc_hold,
   output logic        ifid_stall,
   output logic        ifid_flush,
   output logic        idex_stall,
   output logic        idex_flush,
   output logic        exls_stall,
   output logic        exls_flush,
   output logic [1:0]  ctrl_state,
   output logic        mdu_err,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
);

   localparam int unsigned MduCntW = $clog2(MDU_MAX_CYCLES + 1);
   localparam logic [MduCntW-1:0] MduMax  = MduCntW'(MDU_MAX_CYCLES);
   localparam logic [MduCntW-1:0] MduLast = MduCntW'(MDU_MAX_CYCLES - 1);
   localparam logic [1:0] RedirLoad = 2'(REDIRECT_BUBBLES - 1);

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StMduWait = 2'd1,
      StLsuWait = 2'd2,
      StRedir   = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [1:0]         redir_cnt_q, redir_cnt_d;
   logic [MduCntW-1:0] mdu_cnt_q, mdu_cnt_d;
   logic               mdu_pend_q, mdu_pend_d;
   logic               mdu_err_q, mdu_err_d;
   logic               ls_wait;
   logic               load_use;

   assign ls_wait  = ls_req & ~ls_ack;
   assign load_use = ex_load_flag & ex_rd_ena & (ex_rd_addr != 5'd0) &
                     ((id_rs1_use & (id_rs1_addr == ex_rd_addr)) |
                      (id_rs2_use & (id_rs2_addr == ex_rd_addr)));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StRun;
         redir_cnt_q <= '0;
         mdu_cnt_q   <= '0;
         mdu_pend_q  <= 1'b0;
         mdu_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         redir_cnt_q <= redir_cnt_d;
         mdu_cnt_q   <= mdu_cnt_d;
         mdu_pend_q  <= mdu_pend_d;
         mdu_err_q   <= mdu_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      redir_cnt_d = redir_cnt_q;
      mdu_cnt_d   = mdu_cnt_q;
      mdu_pend_d  = mdu_pend_q;
      mdu_err_d   = mdu_err_q;
      if (trap_flush) begin
         state_d     = StRun;
         redir_cnt_d = '0;
         mdu_cnt_d   = '0;
         mdu_pend_d  = 1'b0;
      end else begin
         unique case (state_q)
            StRun, StRedir: begin
               if (ls_wait) begin
                  state_d    = StLsuWait;
                  mdu_pend_d = 1'b0;
               end else if ((state_q == StRun) && ex_mdu_start && !ex_redirect) begin
                  state_d   = StMduWait;
                  mdu_cnt_d = '0;
               end else if (ex_redirect) begin
                  redir_cnt_d = RedirLoad;
                  state_d     = (REDIRECT_BUBBLES > 1) ? StRedir : StRun;
               end else if (state_q == StRedir) begin
                  if (redir_cnt_q <= 2'd1) begin
                     redir_cnt_d = '0;
                     state_d     = StRun;
                  end else begin
                     redir_cnt_d = redir_cnt_q - 2'd1;
                  end
               end
            end
            StMduWait: begin
               // A memory wait preempts the MDU; remember whether the MDU still owes a result.
               if (ls_wait) begin
                  state_d    = StLsuWait;
                  mdu_pend_d = ~mdu_done;
               end else if (mdu_done) begin
                  state_d = StRun;
               end else begin
                  if (mdu_cnt_q != MduMax) mdu_cnt_d = mdu_cnt_q + 1'b1;
                  if (mdu_cnt_q >= MduLast) mdu_err_d = 1'b1;
               end
            end
            StLsuWait: begin
               if (ls_ack) begin
                  state_d    = (mdu_pend_q && !mdu_done) ? StMduWait : StRun;
                  mdu_pend_d = 1'b0;
               end else if (mdu_done) begin
                  mdu_pend_d = 1'b0;
               end
            end
            default: state_d = StRun;
         endcase
      end
   end

   always_comb begin
      pc_hold    = 1'b0;
      ifid_stall = 1'b0;
      ifid_flush = 1'b0;
      idex_stall = 1'b0;
      idex_flush = 1'b0;
      exls_stall = 1'b0;
      exls_flush = 1'b0;
      if (rst) begin
         if (trap_flush) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            exls_flush = 1'b1;
         end else if ((state_q != StMduWait && state_q != StLsuWait && ls_wait) ||
                      (state_q == StMduWait && ls_wait) ||
                      (state_q == StLsuWait && !ls_ack)) begin
            pc_hold    = 1'b1;
            ifid_stall = 1'b1;
            idex_stall = 1'b1;
            exls_stall = 1'b1;
         end else begin
            unique case (state_q)
               StRun: begin
                  if (ex_mdu_start && !ex_redirect) begin
                     pc_hold    = 1'b1;
                     ifid_stall = 1'b1;
                     idex_stall = 1'b1;
                     exls_flush = 1'b1;
                  end else if (ex_redirect) begin
                     ifid_flush = 1'b1;
                     idex_flush = 1'b1;
                  end else if (load_use) begin
                     pc_hold    = 1'b1;
                     ifid_stall = 1'b1;
                     idex_flush = 1'b1;
                  end
               end
               StRedir: begin
                  ifid_flush = 1'b1;
                  idex_flush = ex_redirect;
               end
               StMduWait: begin
                  if (!mdu_done) begin
                     pc_hold    = 1'b1;
                     ifid_stall = 1'b1;
                     idex_stall = 1'b1;
                     exls_flush = 1'b1;
                  end
               end
               StLsuWait: ;
               default: ;
            endcase
         end
      end
   end

   assign ctrl_state = state_q;
   assign mdu_err    = mdu_err_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_q;
   logic [31:0] perf_flush_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (pc_hold) perf_stall_q <= perf_stall_q + 32'd1;
         if (ifid_flush | idex_flush | exls_flush) perf_flush_q <= perf_flush_q + 32'd1;
      end
   end

   assign perf_stall_cnt = perf_stall_q;
   assign perf_flush_cnt = perf_flush_q;
`else
   assign perf_stall_cnt = '0;
   assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed corner sequences and a
// randomized run against an abstract behavioural model.
module tb_pipe_hazard_ctrl;

   localparam int unsigned Bub    = 3;
   localparam int unsigned MduMax = 8;

   // Control bundle order: {pc_hold, ifid_stall, ifid_flush, idex_stall, idex_flush,
   //                        exls_stall, exls_flush}
   localparam logic [6:0] OutNone = 7'b0000000;
   localparam logic [6:0] OutLu   = 7'b1100100;
   localparam logic [6:0] OutRd   = 7'b0010100;
   localparam logic [6:0] OutRb   = 7'b0010000;
   localparam logic [6:0] OutMd   = 7'b1101001;
   localparam logic [6:0] OutLs   = 7'b1101010;
   localparam logic [6:0] OutTr   = 7'b0010101;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
   logic        id_rs1_use, id_rs2_use, ex_rd_ena, ex_load_flag, ex_redirect, ex_mdu_start;
   logic        mdu_done, ls_req, ls_ack, trap_flush;
   logic        pc_hold, ifid_stall, ifid_flush, idex_stall, idex_flush, exls_stall, exls_flush;
   logic [1:0]  ctrl_state;
   logic        mdu_err;
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
   logic [6:0]  ctl;

   assign ctl = {pc_hold, ifid_stall, ifid_flush, idex_stall, idex_flush, exls_stall, exls_flush};

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(
      .REDIRECT_BUBBLES(Bub),
      .MDU_MAX_CYCLES  (MduMax)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .id_rs1_addr   (id_rs1_addr),
      .id_rs2_addr   (id_rs2_addr),
      .id_rs1_use    (id_rs1_use),
      .id_rs2_use    (id_rs2_use),
      .ex_rd_addr    (ex_rd_addr),
      .ex_rd_ena     (ex_rd_ena),
      .ex_load_flag  (ex_load_flag),
      .ex_redirect   (ex_redirect),
      .ex_mdu_start  (ex_mdu_start),
      .mdu_done      (mdu_done),
      .ls_req        (ls_req),
      .ls_ack        (ls_ack),
      .trap_flush    (trap_flush),
      .pc_hold       (pc_hold),
      .ifid_stall    (ifid_stall),
      .ifid_flush    (ifid_flush),
      .idex_stall    (idex_stall),
      .idex_flush    (idex_flush),
      .exls_stall    (exls_stall),
      .exls_flush    (exls_flush),
      .ctrl_state    (ctrl_state),
      .mdu_err       (mdu_err),
      .perf_stall_cnt(perf_stall_cnt),
      .perf_flush_cnt(perf_flush_cnt)
   );

   int checks = 0;
   int errors = 0;

   // Abstract model: which activities are outstanding, not FSM encodings.
   bit          m_lsu;
   bit          m_mdu;
   int          m_waited;
   int          m_bub;
   bit          m_err;
   logic [31:0] m_pstall, m_pflush;

   typedef struct {
      logic [4:0] rs1, rs2, rd;
      logic       rs1_use, rs2_use, rd_ena, load, redir, mdu, req, ack, trap;
      logic [6:0] exp;
      logic [1:0] nxt;
   } vec_t;

   vec_t vecs [16];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
      id_rs1_use = 0; id_rs2_use = 0; ex_rd_ena = 0; ex_load_flag = 0;
      ex_redirect = 0; ex_mdu_start = 0; mdu_done = 0;
      ls_req = 0; ls_ack = 0; trap_flush = 0;
   endtask

   task automatic model_reset();
      m_lsu = 0; m_mdu = 0; m_waited = 0; m_bub = 0; m_err = 0;
      m_pstall = '0; m_pflush = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_inputs();
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
   endtask

   // Sample at the negedge, then move to just after the next posedge.
   task automatic expect_cycle(input string name, input logic [6:0] e, input logic [1:0] st);
      @(negedge clk);
      chk({name, "_ctl"}, 32'(ctl), 32'(e));
      chk({name, "_state"}, 32'(ctrl_state), 32'(st));
      @(posedge clk);
      #1;
   endtask

   task automatic model_step(output logic [6:0] e, output logic [1:0] st, output logic er);
      bit lw, lu;
      e  = OutNone;
      st = m_lsu ? 2'd2 : m_mdu ? 2'd1 : (m_bub > 0) ? 2'd3 : 2'd0;
      er = m_err;
      lw = ls_req && !ls_ack;
      lu = ex_load_flag && ex_rd_ena && (ex_rd_addr != 0) &&
           ((id_rs1_use && id_rs1_addr == ex_rd_addr) || (id_rs2_use && id_rs2_addr == ex_rd_addr));
      if (!rst) begin
         model_reset();
      end else begin
         if (trap_flush) begin
            e = OutTr;
            m_lsu = 0; m_mdu = 0; m_waited = 0; m_bub = 0;
         end else if (m_lsu) begin
            if (!ls_ack) e = OutLs;
            if (mdu_done) m_mdu = 0;
            if (ls_ack) m_lsu = 0;
         end else if (m_mdu) begin
            if (lw) begin
               e = OutLs;
               m_lsu = 1;
               if (mdu_done) m_mdu = 0;
            end else if (mdu_done) begin
               m_mdu = 0;
            end else begin
               e = OutMd;
               m_waited++;
               if (m_waited >= int'(MduMax)) m_err = 1;
            end
         end else if (lw) begin
            e = OutLs;
            m_lsu = 1;
            m_bub = 0;
         end else if (m_bub == 0 && ex_mdu_start && !ex_redirect) begin
            e = OutMd;
            m_mdu = 1;
            m_waited = 0;
         end else if (ex_redirect) begin
            e = OutRd;
            m_bub = int'(Bub) - 1;
         end else if (m_bub > 0) begin
            e = OutRb;
            m_bub--;
         end else if (lu) begin
            e = OutLu;
         end
         if (e[6]) m_pstall = m_pstall + 32'd1;
         if (e[4] || e[2] || e[0]) m_pflush = m_pflush + 32'd1;
      end
   endtask

   initial begin
      logic [6:0]  e;
      logic [1:0]  st;
      logic        er;
      logic [31:0] ps, pf;

      //          rs1   rs2   rd    u1 u2 en ld rd md rq ak tr exp     nxt
      vecs[0]  = '{5'd0, 5'd5, 5'd5, 0, 1, 1, 1, 0, 0, 0, 0, 0, OutLu,   2'd0};
      vecs[1]  = '{5'd0, 5'd5, 5'd0, 0, 1, 1, 1, 0, 0, 0, 0, 0, OutNone, 2'd0};
      vecs[2]  = '{5'd0, 5'd0, 5'd0, 1, 1, 1, 1, 0, 0, 0, 0, 0, OutNone, 2'd0};
      vecs[3]  = '{5'd7, 5'd0, 5'd7, 1, 0, 1, 1, 0, 0, 0, 0, 0, OutLu,   2'd0};
      vecs[4]  = '{5'd7, 5'd0, 5'd7, 0, 0, 1, 1, 0, 0, 0, 0, 0, OutNone, 2'd0};
      vecs[5]  = '{5'd5, 5'd5, 5'd5, 1, 1, 1, 0, 0, 0, 0, 0, 0, OutNone, 2'd0};
      vecs[6]  = '{5'd5, 5'd5, 5'd5, 1, 1, 0, 1, 0, 0, 0, 0, 0, OutNone, 2'd0};
      vecs[7]  = '{5'd5, 5'd5, 5'd5, 1, 1, 1, 1, 1, 0, 0, 0, 0, OutRd,   2'd3};
      vecs[8]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0, OutMd,   2'd1};
      vecs[9]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1, 0, 0, 0, OutRd,   2'd3};
      vecs[10] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 1, 0, 0, OutLs,   2'd2};
      vecs[11] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 1, 1, 0, OutNone, 2'd0};
      vecs[12] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 1, 0, 0, OutLs,   2'd2};
      vecs[13] = '{5'd5, 5'd5, 5'd5, 1, 1, 1, 1, 0, 0, 0, 0, 1, OutTr,   2'd0};
      vecs[14] = '{5'd5, 5'd5, 5'd5, 1, 1, 1, 1, 0, 0, 1, 1, 0, OutLu,   2'd0};
      vecs[15] = '{5'd5, 5'd5, 5'd5, 1, 1, 1, 1, 0, 1, 0, 0, 0, OutMd,   2'd1};

      // Reset state
      do_reset();
      @(negedge clk);
      chk("reset_ctl", 32'(ctl), 32'(OutNone));
      chk("reset_state", 32'(ctrl_state), 32'd0);
      chk("reset_err", 32'(mdu_err), 32'd0);
      chk("reset_perf_stall", perf_stall_cnt, 32'd0);
      chk("reset_perf_flush", perf_flush_cnt, 32'd0);

      // Single-cycle decisions from RUN
      for (int i = 0; i < 16; i++) begin
         do_reset();
         id_rs1_addr = vecs[i].rs1; id_rs2_addr = vecs[i].rs2; ex_rd_addr = vecs[i].rd;
         id_rs1_use = vecs[i].rs1_use; id_rs2_use = vecs[i].rs2_use;
         ex_rd_ena = vecs[i].rd_ena; ex_load_flag = vecs[i].load;
         ex_redirect = vecs[i].redir; ex_mdu_start = vecs[i].mdu;
         ls_req = vecs[i].req; ls_ack = vecs[i].ack; trap_flush = vecs[i].trap;
         @(negedge clk);
         chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vecs[i].exp));
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_next", i), 32'(ctrl_state), 32'(vecs[i].nxt));
      end

      // Redirect with three bubbles
      do_reset();
      ex_redirect = 1;
      expect_cycle("redir0", OutRd, 2'd0);
      ex_redirect = 0;
      expect_cycle("redir1", OutRb, 2'd3);
      expect_cycle("redir2", OutRb, 2'd3);
      expect_cycle("redir3", OutNone, 2'd0);

      // MDU completes four cycles after start
      do_reset();
      ex_mdu_start = 1;
      expect_cycle("mdu0", OutMd, 2'd0);
      ex_mdu_start = 0;
      for (int i = 1; i < 4; i++) expect_cycle($sformatf("mdu%0d", i), OutMd, 2'd1);
      mdu_done = 1;
      expect_cycle("mdu_done", OutNone, 2'd1);
      mdu_done = 0;
      expect_cycle("mdu_after", OutNone, 2'd0);

      // MDU timeout raises a sticky error
      do_reset();
      ex_mdu_start = 1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk($sformatf("mdu_err_c%0d", c), 32'(mdu_err), (c >= 9) ? 32'd1 : 32'd0);
         @(posedge clk);
         #1;
         ex_mdu_start = 0;
      end
      mdu_done = 1;
      expect_cycle("mdu_late_done", OutNone, 2'd1);
      mdu_done = 0;
      trap_flush = 1;
      expect_cycle("trap_run", OutTr, 2'd0);
      trap_flush = 0;
      @(negedge clk);
      chk("mdu_err_sticky", 32'(mdu_err), 32'd1);
      do_reset();
      @(negedge clk);
      chk("mdu_err_cleared", 32'(mdu_err), 32'd0);

      // LSU wait of three cycles then acknowledge
      do_reset();
      ls_req = 1;
      expect_cycle("lsu0", OutLs, 2'd0);
      expect_cycle("lsu1", OutLs, 2'd2);
      expect_cycle("lsu2", OutLs, 2'd2);
      ls_ack = 1;
      expect_cycle("lsu_ack", OutNone, 2'd2);
      ls_req = 0; ls_ack = 0;
      expect_cycle("lsu_done", OutNone, 2'd0);

      // Trap while waiting on the MDU
      do_reset();
      ex_mdu_start = 1;
      expect_cycle("trapm0", OutMd, 2'd0);
      ex_mdu_start = 0;
      trap_flush = 1;
      expect_cycle("trap_mdu", OutTr, 2'd1);
      trap_flush = 0;
      expect_cycle("trap_after", OutNone, 2'd0);

      // Reset asserted in the middle of an LSU wait
      do_reset();
      ls_req = 1;
      expect_cycle("rstl0", OutLs, 2'd0);
      expect_cycle("rstl1", OutLs, 2'd2);
      rst = 0;
      @(negedge clk);
      chk("rst_force_ctl", 32'(ctl), 32'(OutNone));
`ifdef PIPE_CTRL_PERF_EN
      chk("perf_stall_pre", perf_stall_cnt, 32'd2);
`endif
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_mid_state", 32'(ctrl_state), 32'd0);
      chk("rst_mid_ctl", 32'(ctl), 32'(OutNone));
      chk("rst_mid_perf_stall", perf_stall_cnt, 32'd0);
      chk("rst_mid_perf_flush", perf_flush_cnt, 32'd0);
      @(posedge clk);
      #1;

      // Randomized run against the model
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         rst          = ($urandom_range(0, 299) != 0);
         id_rs1_addr  = 5'($urandom_range(0, 3));
         id_rs2_addr  = 5'($urandom_range(0, 3));
         ex_rd_addr   = 5'($urandom_range(0, 3));
         id_rs1_use   = ($urandom_range(0, 1) != 0);
         id_rs2_use   = ($urandom_range(0, 1) != 0);
         ex_rd_ena    = ($urandom_range(0, 3) != 0);
         ex_load_flag = ($urandom_range(0, 1) != 0);
         ex_redirect  = ($urandom_range(0, 7) == 0);
         ex_mdu_start = ($urandom_range(0, 5) == 0);
         mdu_done     = ($urandom_range(0, 9) == 0);
         ls_req       = ($urandom_range(0, 4) == 0);
         ls_ack       = ($urandom_range(0, 2) == 0);
         trap_flush   = ($urandom_range(0, 49) == 0);
         @(negedge clk);
         ps = m_pstall;
         pf = m_pflush;
         model_step(e, st, er);
         chk("rnd_ctl", 32'(ctl), 32'(e));
         chk("rnd_state", 32'(ctrl_state), 32'(st));
         chk("rnd_err", 32'(mdu_err), 32'(er));
`ifdef PIPE_CTRL_PERF_EN
         chk("rnd_perf_stall", perf_stall_cnt, ps);
         chk("rnd_perf_flush", perf_flush_cnt, pf);
`else
         chk("rnd_perf_tied", perf_stall_cnt | perf_flush_cnt, 32'd0);
`endif
         @(posedge clk);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
